// File: rtl/wb_regfile.sv
// ---------------------------------------------------------------------------
// wb_regfile
//
// Write-back stage and register file of the pipelined MIPS datapath. It sits
// at the consuming end of the MEM/WB pipeline register. Each cycle it picks
// the write-back value (load data or ALU result) and commits it to a
// 2^ADDR_W x DATA_W register file. It also serves the two ID-stage read ports
// with a same-cycle write-through bypass, and counts committed writes for
// debug visibility.
//
// Parameters
//   DATA_W   register / data width
//   ADDR_W   register index width (2^ADDR_W registers)
//   CNT_W    width of the committed-write counter (wraps silently)
//
// Ports
//   clk          in   pipeline clock, all state changes on the rising edge
//   rst_n        in   asynchronous active-low reset (clears regs and count)
//   RegWrite_WB  in   write enable from MEM/WB
//   MemToReg_WB  in   1 = write back MemRes_WB, 0 = write back ALURes_WB
//   MemRes_WB    in   load data from MEM/WB
//   ALURes_WB    in   ALU result from MEM/WB
//   WREG_WB      in   destination register index
//   RA1, RA2     in   ID-stage read indices
//   RD1, RD2     out  read data, combinational, with write-through bypass
//   WData        out  selected write-back value, for EX-stage forwarding
//   WrCount      out  number of committed register writes
// ---------------------------------------------------------------------------
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWrite_WB,
  input  logic              MemToReg_WB,
  input  logic [DATA_W-1:0] MemRes_WB,
  input  logic [DATA_W-1:0] ALURes_WB,
  input  logic [ADDR_W-1:0] WREG_WB,
  input  logic [ADDR_W-1:0] RA1,
  input  logic [ADDR_W-1:0] RA2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic [DATA_W-1:0] WData,
  output logic [CNT_W-1:0]  WrCount
);

  localparam int NREG = 1 << ADDR_W;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DATA_W-1:0] regs [NREG];
  logic [CNT_W-1:0]  wr_count;
  logic              we_eff;

  // The write-back mux is live every cycle, independent of RegWrite_WB, so
  // the EX stage can always forward from it.
  assign WData = MemToReg_WB ? MemRes_WB : ALURes_WB;

  // r0 is hard-wired to zero, so writes aimed at it are not commits at all:
  // they neither store nor count.
  assign we_eff = RegWrite_WB && (WREG_WB != '0);

  // Storage and commit counter. Entry 0 is cleared on reset and never
  // written afterwards, and the read ports force it to zero anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs     <= '{default: '0};
      wr_count <= '0;
    end else if (we_eff) begin
      regs[WREG_WB] <= WData;
      wr_count      <= wr_count + CNT_ONE;
    end
  end

  assign WrCount = wr_count;

  // Read port 1. The bypass lets an ID-stage read see the value being
  // committed in the same cycle, which removes the WB/ID structural hazard.
  // It is purely combinational, so it keeps working while reset is held.
  always_comb begin
    RD1 = '0;
    if (RA1 != '0) begin
      if (we_eff && (RA1 == WREG_WB)) begin
        RD1 = WData;
      end else begin
        RD1 = regs[RA1];
      end
    end
  end

  // Read port 2, identical to port 1 and evaluated independently.
  always_comb begin
    RD2 = '0;
    if (RA2 != '0) begin
      if (we_eff && (RA2 == WREG_WB)) begin
        RD2 = WData;
      end else begin
        RD2 = regs[RA2];
      end
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
`timescale 1ns/10ps
// ---------------------------------------------------------------------------
// tb_wb_regfile
//
// Directed self-checking bench for wb_regfile. A table of vectors covers the
// write-back mux, r0 protection, bypass and back-to-back writes; hand-written
// sequences cover reset behaviour, an asynchronous reset pulse between clock
// edges, and counter wrap on a second instance built with CNT_W = 4.
// ---------------------------------------------------------------------------
module tb_wb_regfile;

  logic        clk;
  logic        rst_n;
  logic        reg_write;
  logic        mem_to_reg;
  logic [31:0] mem_res;
  logic [31:0] alu_res;
  logic [4:0]  wreg;
  logic [4:0]  ra1;
  logic [4:0]  ra2;

  logic [31:0] rd1, rd2, wdata, wr_count;
  logic [31:0] rd1_n4, rd2_n4, wdata_n4;
  logic [3:0]  wr_count_n4;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    logic        we;
    logic        m2r;
    logic [31:0] mem;
    logic [31:0] alu;
    logic [4:0]  wr;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rd1;
    logic [31:0] exp_rd2;
    logic [31:0] exp_cnt;
  } vec_t;

  vec_t vecs [13];

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .RegWrite_WB (reg_write),
    .MemToReg_WB (mem_to_reg),
    .MemRes_WB   (mem_res),
    .ALURes_WB   (alu_res),
    .WREG_WB     (wreg),
    .RA1         (ra1),
    .RA2         (ra2),
    .RD1         (rd1),
    .RD2         (rd2),
    .WData       (wdata),
    .WrCount     (wr_count)
  );

  wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) u_dut_cnt4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .RegWrite_WB (reg_write),
    .MemToReg_WB (mem_to_reg),
    .MemRes_WB   (mem_res),
    .ALURes_WB   (alu_res),
    .WREG_WB     (wreg),
    .RA1         (ra1),
    .RA2         (ra2),
    .RD1         (rd1_n4),
    .RD2         (rd2_n4),
    .WData       (wdata_n4),
    .WrCount     (wr_count_n4)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic drive(input logic we, input logic m2r, input logic [31:0] mem,
                       input logic [31:0] alu, input logic [4:0] wr,
                       input logic [4:0] a1, input logic [4:0] a2);
    reg_write  = we;
    mem_to_reg = m2r;
    mem_res    = mem;
    alu_res    = alu;
    wreg       = wr;
    ra1        = a1;
    ra2        = a2;
  endtask

  task automatic apply_stimulus(input vec_t v, input int idx);
    @(negedge clk);
    drive(v.we, v.m2r, v.mem, v.alu, v.wr, v.a1, v.a2);
    #2;
    check_output($sformatf("vec%0d WData", idx), wdata, v.exp_wdata);
    check_output($sformatf("vec%0d RD1", idx), rd1, v.exp_rd1);
    check_output($sformatf("vec%0d RD2", idx), rd2, v.exp_rd2);
    @(posedge clk);
    #1;
    check_output($sformatf("vec%0d WrCount", idx), wr_count, v.exp_cnt);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  task automatic commit_write(input logic [4:0] wr, input logic [31:0] val);
    @(negedge clk);
    drive(1'b1, 1'b0, 32'h0, val, wr, 5'd0, 5'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Table: starts right after reset release, everything zero.
    vecs[0]  = '{1'b1, 1'b0, 32'h0,        32'hDEADBEEF, 5'd5, 5'd5, 5'd31, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0,        32'd1};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,        32'h0,        5'd0, 5'd5, 5'd0,  32'h0,        32'hDEADBEEF, 32'h0,        32'd1};
    vecs[2]  = '{1'b1, 1'b1, 32'h12345678, 32'hAAAAAAAA, 5'd9, 5'd5, 5'd9,  32'h12345678, 32'hDEADBEEF, 32'h12345678, 32'd2};
    vecs[3]  = '{1'b1, 1'b0, 32'h12345678, 32'hAAAAAAAA, 5'd9, 5'd9, 5'd0,  32'hAAAAAAAA, 32'hAAAAAAAA, 32'h0,        32'd3};
    vecs[4]  = '{1'b0, 1'b0, 32'h0,        32'h0,        5'd0, 5'd9, 5'd5,  32'h0,        32'hAAAAAAAA, 32'hDEADBEEF, 32'd3};
    vecs[5]  = '{1'b1, 1'b0, 32'h0,        32'hFFFFFFFF, 5'd0, 5'd0, 5'd9,  32'hFFFFFFFF, 32'h0,        32'hAAAAAAAA, 32'd3};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,        32'h0,        5'd0, 5'd0, 5'd0,  32'h0,        32'h0,        32'h0,        32'd3};
    vecs[7]  = '{1'b1, 1'b0, 32'h0,        32'h11,       5'd7, 5'd5, 5'd9,  32'h11,       32'hDEADBEEF, 32'hAAAAAAAA, 32'd4};
    vecs[8]  = '{1'b0, 1'b0, 32'h0,        32'h22,       5'd7, 5'd7, 5'd7,  32'h22,       32'h11,       32'h11,       32'd4};
    vecs[9]  = '{1'b1, 1'b0, 32'h0,        32'h22,       5'd7, 5'd7, 5'd7,  32'h22,       32'h22,       32'h22,       32'd5};
    vecs[10] = '{1'b1, 1'b1, 32'h33,       32'h0,        5'd7, 5'd7, 5'd5,  32'h33,       32'h33,       32'hDEADBEEF, 32'd6};
    vecs[11] = '{1'b0, 1'b0, 32'h0,        32'h0,        5'd0, 5'd7, 5'd7,  32'h0,        32'h33,       32'h33,       32'd6};
    vecs[12] = '{1'b1, 1'b0, 32'h0,        32'h44,       5'd3, 5'd7, 5'd3,  32'h44,       32'h33,       32'h44,       32'd7};

    // Held in reset from time zero.
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd31);
    #2;
    check_output("reset RD1", rd1, 32'h0);
    check_output("reset RD2", rd2, 32'h0);
    check_output("reset WrCount", wr_count, 32'h0);

    // A write presented during reset: bypass still answers, nothing commits.
    drive(1'b1, 1'b0, 32'h0, 32'h99, 5'd5, 5'd3, 5'd5);
    #1;
    check_output("reset bypass RD2", rd2, 32'h99);
    check_output("reset RD1 r3", rd1, 32'h0);
    @(posedge clk);
    #1;
    check_output("reset write WrCount", wr_count, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd5, 5'd5);
    rst_n = 1'b1;
    #1;
    check_output("reset write dropped", rd1, 32'h0);

    for (int i = 0; i < 13; i++) begin
      apply_stimulus(vecs[i], i);
    end

    // Fill r1..r31 with their index after a clean reset.
    pulse_reset();
    for (int i = 1; i < 32; i++) begin
      commit_write(5'(i), 32'(i));
    end
    check_output("fill WrCount", wr_count, 32'd31);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0);
    for (int i = 1; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(32 - i);
      #0.2;
      check_output($sformatf("fill RD1 r%0d", i), rd1, 32'(i));
      check_output($sformatf("fill RD2 r%0d", 32 - i), rd2, 32'(32 - i));
    end

    // Short async reset pulse strictly between edges.
    @(negedge clk);
    #0.5 rst_n = 1'b0;
    #1;
    check_output("pulse WrCount low", wr_count, 32'd0);
    #2 rst_n = 1'b1;
    check_output("pulse WrCount", wr_count, 32'd0);
    for (int i = 1; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(32 - i);
      #0.1;
      check_output($sformatf("pulse RD1 r%0d", i), rd1, 32'h0);
      check_output($sformatf("pulse RD2 r%0d", 32 - i), rd2, 32'h0);
    end

    // Counter wrap on the 4-bit instance: 17 commits -> 1.
    pulse_reset();
    for (int i = 0; i < 17; i++) begin
      commit_write(5'((i % 31) + 1), 32'h100 + 32'(i));
    end
    check_output("wrap WrCount cnt4", {28'h0, wr_count_n4}, 32'd1);
    check_output("wrap WrCount cnt32", wr_count, 32'd17);
    @(negedge clk);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd1, 5'd17);
    #1;
    check_output("wrap RD1 r1 last", rd1, 32'h100);
    check_output("wrap RD2 r17", rd2, 32'h110);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
